mem_arbiter: RTL

Two-port arbiter that shares the single-port 32-bit SOC memory (one read strobe, 4-bit byte write mask, fixed one-cycle read latency) between two requesters. Port 0 is the processor's instruction/load/store port; port 1 is a secondary master, such as a UART program loader or a debug/DMA engine. The block sits between the requesters and the memory in the SOC. It latches the winning request, issues exactly one memory access, and returns read data with a one-cycle ready pulse.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/rr_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // FSM encoding: IDLE arbitrates, ISSUE drives the memory, RESP returns data.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Requester indices, also used as bit positions in valid/grant vectors.
  localparam int PORT_CPU = 0;
  localparam int PORT_AUX = 1;

  // Memory data bus geometry.
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // A zero byte mask marks a read; any set lane marks a write.
  function automatic logic is_read(input logic [MASK_W-1:0] mask);
    return (mask == '0);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way request selector: round-robin or fixed port-0 priority.
// Latency: purely combinational.
// Backpressure: none; the caller only consumes the result while idle.
//
// Ports:
//   valid : per-port request vector (bit PORT_CPU, bit PORT_AUX)
//   last  : port served most recently (1 = port 1)
//   win   : one-hot winner, 00 when no request
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (valid[PORT_CPU] && valid[PORT_AUX]) begin
      // Contested: fixed mode always favours port 0; round-robin favours
      // whichever port did not get the previous access.
      if ((PRIO_FIXED != 0) || last) begin
        win[PORT_CPU] = 1'b1;
      end else begin
        win[PORT_AUX] = 1'b1;
      end
    end else begin
      win = valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 32-bit memory between a CPU port and an aux master.
// Latency: request sampled in IDLE cycle T -> memory strobe T+1 -> ready T+2.
// Backpressure: requesters hold valid until their one-cycle ready pulse;
//   one access is in flight at a time (at most one access per 3 cycles).
//
// Ports:
//   clk, resetn                : clock, synchronous active-low reset
//   m0_* / m1_*                : requester ports (valid, addr, wdata, wmask in;
//                                ready pulse and rdata out)
//   mem_addr/wdata/wmask/rstrb : registered memory command
//   mem_rdata                  : memory read data, valid the cycle after rstrb
//   grant                      : one-hot owner of the access in flight
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PRIO_FIXED = 0
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [MASK_W-1:0]     m0_wmask,
  output logic                  m0_ready,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [MASK_W-1:0]     m1_wmask,
  output logic                  m1_ready,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MASK_W-1:0]     mem_wmask,
  output logic                  mem_rstrb,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic [1:0]            grant
);

  state_t                state;
  logic                  last;      // 1 = port 1 was served last
  logic [1:0]            valid;
  logic [1:0]            win;

  logic                  take_aux;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [MASK_W-1:0]     sel_wmask;

  assign valid = {m1_valid, m0_valid};

  rr_pick #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_pick (
    .valid (valid),
    .last  (last),
    .win   (win)
  );

  // Winner's request fields, only consumed on the IDLE -> ISSUE edge.
  assign take_aux  = win[PORT_AUX];
  assign sel_addr  = take_aux ? m1_addr  : m0_addr;
  assign sel_wdata = take_aux ? m1_wdata : m0_wdata;
  assign sel_wmask = take_aux ? m1_wmask : m0_wmask;

  // Read data is a straight pass-through; ready qualifies it.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  // mem_addr / mem_wdata double as the latched request: they are loaded once
  // at grant and hold until the next grant, so requester changes after the
  // grant cannot disturb the access in flight. The write mask is only needed
  // during ISSUE, so it lives directly in mem_wmask.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      grant     <= 2'b00;
      last      <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_rstrb <= 1'b0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          if (|win) begin
            state     <= ST_ISSUE;
            grant     <= win;
            last      <= take_aux;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wmask <= sel_wmask;
            mem_rstrb <= is_read(sel_wmask);
          end
        end

        ST_ISSUE: begin
          // The command was visible to the memory for exactly this cycle.
          state     <= ST_RESP;
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          m0_ready  <= grant[PORT_CPU];
          m1_ready  <= grant[PORT_AUX];
        end

        ST_RESP: begin
          state    <= ST_IDLE;
          grant    <= 2'b00;
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          grant     <= 2'b00;
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          m0_ready  <= 1'b0;
          m1_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
